// File: rtl/guess_game_pkg.sv
// Shared types for the number-guessing game controller: FSM state codes,
// LCD command codes and the trial-counter width.
package guess_game_pkg;

    localparam int TW = 4;

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_WAIT = 3'b001,
        ST_HINT = 3'b010,
        ST_END  = 3'b011
    } state_t;

    typedef enum logic [2:0] {
        CMD_CORRECT = 3'b000,
        CMD_FAILED  = 3'b001,
        CMD_UP      = 3'b010,
        CMD_DOWN    = 3'b011,
        CMD_RETRY   = 3'b100,
        CMD_START   = 3'b101,
        CMD_ENTER   = 3'b110,
        CMD_RANGE   = 3'b111
    } cmd_t;

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Keypad/LCD-side signal bundle of the guessing game controller.
// The master drives guesses and the random word; the slave is the controller.
interface guess_game_ctrl_if #(
    parameter int W = 7
);
    logic [W-1:0]                    rand_in;
    logic [W-1:0]                    guess_in;
    logic                            guess_valid;
    logic                            guess_ready;
    logic [2:0]                      cmd_out;
    logic                            cmd_strobe;
    logic [guess_game_pkg::TW-1:0]   trials_left;
    logic [W-1:0]                    lo_bound;
    logic [W-1:0]                    hi_bound;
    logic [7:0]                      win_cnt;
    logic [2:0]                      game_state;

    modport master (
        output rand_in, guess_in, guess_valid,
        input  guess_ready, cmd_out, cmd_strobe, trials_left,
               lo_bound, hi_bound, win_cnt, game_state
    );

    modport slave (
        input  rand_in, guess_in, guess_valid,
        output guess_ready, cmd_out, cmd_strobe, trials_left,
               lo_bound, hi_bound, win_cnt, game_state
    );
endinterface

// File: rtl/guess_timeout_timer.sv
// Idle-cycle counter for the guess timeout; expire pulses on the cycle the
// count reaches CYC-1 while enabled and not being cleared.
module guess_timeout_timer #(
    parameter int CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int            CW   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [CW-1:0] r_count;

    assign expire = enable && !clear && (r_count == LAST);

    // Held at zero outside the enabled window, so entering it always starts fresh.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear || expire || !enable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: picks a target, grades guesses into LCD
// commands, tracks hint bounds, remaining trials and won rounds.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int W            = 7,
    parameter int MAX_VAL      = 99,
    parameter int MAX_TRIALS   = 5,
    parameter int TIMEOUT_CYC  = 0,
    parameter int STRICT_RANGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    guess_game_ctrl_if.slave  bus
);
    localparam logic [W-1:0]  MAXV   = W'(MAX_VAL);
    localparam logic [W-1:0]  WRAP   = W'(MAX_VAL + 1);
    localparam logic [TW-1:0] NTRIAL = TW'(MAX_TRIALS);

    state_t        r_state,  w_stateNext;
    cmd_t          r_cmd,    w_cmdNext;
    logic          r_strobe, w_strobeNext;
    logic [TW-1:0] r_trials, w_trialsNext, w_trialsDec;
    logic [W-1:0]  r_lo,     w_loNext;
    logic [W-1:0]  r_hi,     w_hiNext;
    logic [7:0]    r_win,    w_winNext;
    logic [W-1:0]  r_target, w_targetNext;
    logic          w_illegal;
    logic          w_expire;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            logic w_timerClear;
            logic w_timerEnable;
            assign w_timerClear  = bus.guess_valid;
            assign w_timerEnable = (r_state == ST_WAIT);
            guess_timeout_timer #(.CYC(TIMEOUT_CYC)) u_timer (
                .clk    (clk),
                .rst    (rst),
                .clear  (w_timerClear),
                .enable (w_timerEnable),
                .expire (w_expire)
            );
        end else begin : g_noTimer
            assign w_expire = 1'b0;
        end
    endgenerate

    assign w_trialsDec = r_trials - TW'(1);
    assign w_illegal   = (bus.guess_in > MAXV) ||
                         ((STRICT_RANGE != 0) && ((bus.guess_in < r_lo) || (bus.guess_in > r_hi)));

    always_comb begin
        w_stateNext  = r_state;
        w_cmdNext    = r_cmd;
        w_strobeNext = 1'b0;
        w_trialsNext = r_trials;
        w_loNext     = r_lo;
        w_hiNext     = r_hi;
        w_winNext    = r_win;
        w_targetNext = r_target;
        case (r_state)
            ST_INIT: begin
                w_targetNext = (bus.rand_in <= MAXV) ? bus.rand_in : bus.rand_in - WRAP;
                w_trialsNext = NTRIAL;
                w_loNext     = '0;
                w_hiNext     = MAXV;
                w_cmdNext    = CMD_ENTER;
                w_strobeNext = 1'b1;
                w_stateNext  = ST_WAIT;
            end
            ST_WAIT: begin
                // A guess in the same cycle as the timeout wins over the forfeit.
                if (bus.guess_valid) begin
                    w_strobeNext = 1'b1;
                    if (w_illegal) begin
                        w_cmdNext = CMD_RANGE;
                    end else if (bus.guess_in == r_target) begin
                        w_cmdNext   = CMD_CORRECT;
                        w_winNext   = (r_win == 8'hFF) ? r_win : r_win + 8'd1;
                        w_stateNext = ST_END;
                    end else begin
                        w_trialsNext = w_trialsDec;
                        if (w_trialsDec == '0) begin
                            w_cmdNext   = CMD_FAILED;
                            w_stateNext = ST_END;
                        end else if (bus.guess_in > r_target) begin
                            w_cmdNext   = CMD_DOWN;
                            w_hiNext    = bus.guess_in - 1'b1;
                            w_stateNext = ST_HINT;
                        end else begin
                            w_cmdNext   = CMD_UP;
                            w_loNext    = bus.guess_in + 1'b1;
                            w_stateNext = ST_HINT;
                        end
                    end
                end else if (w_expire) begin
                    w_strobeNext = 1'b1;
                    w_trialsNext = w_trialsDec;
                    if (w_trialsDec == '0) begin
                        w_cmdNext   = CMD_FAILED;
                        w_stateNext = ST_END;
                    end else begin
                        w_cmdNext = CMD_ENTER;
                    end
                end
            end
            ST_HINT: begin
                w_stateNext = ST_WAIT;
            end
            ST_END: begin
                if (bus.guess_valid) begin
                    w_strobeNext = 1'b1;
                    if (bus.guess_in == W'(1)) begin
                        w_cmdNext   = CMD_START;
                        w_stateNext = ST_INIT;
                    end else begin
                        w_cmdNext = CMD_RETRY;
                    end
                end
            end
            default: begin
                w_stateNext = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_INIT;
            r_cmd    <= CMD_ENTER;
            r_strobe <= 1'b0;
            r_trials <= '0;
            r_lo     <= '0;
            r_hi     <= MAXV;
            r_win    <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_cmd    <= w_cmdNext;
            r_strobe <= w_strobeNext;
            r_trials <= w_trialsNext;
            r_lo     <= w_loNext;
            r_hi     <= w_hiNext;
            r_win    <= w_winNext;
            r_target <= w_targetNext;
        end
    end

    assign bus.guess_ready = (r_state == ST_WAIT) || (r_state == ST_END);
    assign bus.cmd_out     = r_cmd;
    assign bus.cmd_strobe  = r_strobe;
    assign bus.trials_left = r_trials;
    assign bus.lo_bound    = r_lo;
    assign bus.hi_bound    = r_hi;
    assign bus.win_cnt     = r_win;
    assign bus.game_state  = r_state;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: a rule-level game model queues the
// expected response to every stimulus; a monitor checks each cmd_strobe.
module tb_guess_game_ctrl;

    localparam int MAXV    = 99;
    localparam int NTRIALS = 5;
    localparam int TO_CYC  = 20;

    localparam int MODE_INIT = 0;
    localparam int MODE_WAIT = 1;
    localparam int MODE_HINT = 2;
    localparam int MODE_END  = 3;

    localparam int C_CORRECT = 0;
    localparam int C_FAILED  = 1;
    localparam int C_UP      = 2;
    localparam int C_DOWN    = 3;
    localparam int C_RETRY   = 4;
    localparam int C_START   = 5;
    localparam int C_ENTER   = 6;
    localparam int C_RANGE   = 7;

    typedef struct {
        int cmd;
        int trials;
        int lo;
        int hi;
        int wins;
        int st;
    } exp_t;

    logic clk;
    logic rst;
    int   checksTotal;
    int   checksPassed;
    exp_t expQ[$];

    int mMode;
    int mTarget;
    int mTrials;
    int mLo;
    int mHi;
    int mWins;
    int mIdle;

    guess_game_ctrl_if #(.W(7)) bus ();

    guess_game_ctrl #(
        .W            (7),
        .MAX_VAL      (MAXV),
        .MAX_TRIALS   (NTRIALS),
        .TIMEOUT_CYC  (TO_CYC),
        .STRICT_RANGE (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic pushExp(input int cmd);
        exp_t e;
        e.cmd = cmd; e.trials = mTrials; e.lo = mLo; e.hi = mHi; e.wins = mWins; e.st = mMode;
        expQ.push_back(e);
    endtask

    // What the next clock edge does to the game, stated as the game rules.
    task automatic modelStep(input bit v, input int g, input int r);
        case (mMode)
            MODE_INIT: begin
                mTarget = (r <= MAXV) ? r : r - (MAXV + 1);
                mTrials = NTRIALS; mLo = 0; mHi = MAXV; mIdle = 0;
                mMode = MODE_WAIT;
                pushExp(C_ENTER);
            end
            MODE_HINT: begin
                mMode = MODE_WAIT; mIdle = 0;
            end
            MODE_WAIT: begin
                if (v) begin
                    mIdle = 0;
                    if (g > MAXV || g < mLo || g > mHi) begin
                        pushExp(C_RANGE);
                    end else if (g == mTarget) begin
                        mWins = (mWins < 255) ? mWins + 1 : 255;
                        mMode = MODE_END;
                        pushExp(C_CORRECT);
                    end else begin
                        mTrials--;
                        if (mTrials == 0) begin
                            mMode = MODE_END; pushExp(C_FAILED);
                        end else if (g > mTarget) begin
                            mHi = g - 1; mMode = MODE_HINT; pushExp(C_DOWN);
                        end else begin
                            mLo = g + 1; mMode = MODE_HINT; pushExp(C_UP);
                        end
                    end
                end else if (mIdle == TO_CYC - 1) begin
                    mIdle = 0;
                    mTrials--;
                    if (mTrials == 0) begin
                        mMode = MODE_END; pushExp(C_FAILED);
                    end else begin
                        pushExp(C_ENTER);
                    end
                end else begin
                    mIdle++;
                end
            end
            default: begin
                if (v) begin
                    if (g == 1) begin
                        mMode = MODE_INIT; pushExp(C_START);
                    end else begin
                        pushExp(C_RETRY);
                    end
                end
            end
        endcase
    endtask

    // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
    task automatic applyStimulus(input bit v, input int g, input int r);
        bus.guess_valid = v;
        bus.guess_in    = 7'(g);
        bus.rand_in     = 7'(r);
        modelStep(v, g, r);
        @(negedge clk);
        bus.guess_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom % 128, $urandom % 128);
    endtask

    task automatic guess(input int g);
        applyStimulus(1'b1, g, $urandom % 128);
    endtask

    task automatic doReset();
        rst = 1'b0;
        bus.guess_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_state",  int'(bus.game_state), MODE_INIT);
        checkOutput("reset_cmd",    int'(bus.cmd_out), C_ENTER);
        checkOutput("reset_strobe", int'(bus.cmd_strobe), 0);
        checkOutput("reset_trials", int'(bus.trials_left), 0);
        checkOutput("reset_lo",     int'(bus.lo_bound), 0);
        checkOutput("reset_hi",     int'(bus.hi_bound), MAXV);
        checkOutput("reset_wins",   int'(bus.win_cnt), 0);
        checkOutput("reset_ready",  int'(bus.guess_ready), 0);
        mMode = MODE_INIT; mTrials = 0; mLo = 0; mHi = MAXV; mWins = 0; mTarget = 0; mIdle = 0;
        rst = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (rst && bus.cmd_strobe) begin
                checksTotal++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL unexpected_strobe: got cmd %0d state %0d, no response was due",
                             bus.cmd_out, bus.game_state);
                end else begin
                    e = expQ.pop_front();
                    if (int'(bus.cmd_out) == e.cmd && int'(bus.trials_left) == e.trials &&
                        int'(bus.lo_bound) == e.lo && int'(bus.hi_bound) == e.hi &&
                        int'(bus.win_cnt) == e.wins && int'(bus.game_state) == e.st) begin
                        checksPassed++;
                    end else begin
                        $display("[TB] FAIL strobe_response: got cmd=%0d trials=%0d lo=%0d hi=%0d wins=%0d st=%0d expected cmd=%0d trials=%0d lo=%0d hi=%0d wins=%0d st=%0d",
                                 bus.cmd_out, bus.trials_left, bus.lo_bound, bus.hi_bound, bus.win_cnt, bus.game_state,
                                 e.cmd, e.trials, e.lo, e.hi, e.wins, e.st);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checksTotal = 0;
        checksPassed = 0;
        rst = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess_in = '0;
        bus.rand_in = '0;
        @(negedge clk);
        doReset();

        // Round 1: target 42, guess ignored while in INIT, then a direct hit.
        applyStimulus(1'b1, 42, 42);
        checkOutput("after_init_ready", int'(bus.guess_ready), 1);
        guess(42);
        checkOutput("win_after_hit", int'(bus.win_cnt), 1);

        // Round 2: target 57 with one down and one up hint.
        guess(1);
        applyStimulus(1'b0, 0, 57);
        guess(80);
        applyStimulus(1'b1, 55, 3);
        guess(30);
        idleCycles(1);
        guess(57);
        checkOutput("trials_after_win", int'(bus.trials_left), 3);

        // Round 3: random word 120 folds to target 20; lose, retry, restart.
        guess(1);
        applyStimulus(1'b0, 0, 120);
        for (int i = 10; i <= 13; i++) begin
            guess(i);
            idleCycles(1);
        end
        guess(14);
        checkOutput("lost_state", int'(bus.game_state), MODE_END);
        guess(5);
        guess(1);
        checkOutput("start_cmd", int'(bus.cmd_out), C_START);
        checkOutput("start_state", int'(bus.game_state), MODE_INIT);

        // Round 4: target 50, range rejection, timeout forfeit and guess-beats-timeout.
        applyStimulus(1'b0, 0, 50);
        checkOutput("restart_trials", int'(bus.trials_left), NTRIALS);
        guess(70);
        idleCycles(1);
        guess(75);
        guess(120);
        checkOutput("range_keeps_trials", int'(bus.trials_left), 4);
        idleCycles(TO_CYC);
        checkOutput("timeout_trials", int'(bus.trials_left), 3);
        idleCycles(TO_CYC - 1);
        guess(40);
        checkOutput("guess_beats_timeout", int'(bus.trials_left), 2);
        idleCycles(1);
        guess(60);
        doReset();

        // Randomized play against the model.
        for (int n = 0; n < 1500; n++) begin
            int sel;
            int g;
            sel = $urandom % 8;
            if (sel == 0)      g = $urandom % 128;
            else if (sel == 1) g = 1;
            else               g = mLo + ($urandom % (mHi - mLo + 1));
            if ($urandom % 60 == 0) idleCycles(TO_CYC + ($urandom % 3));
            applyStimulus(($urandom % 4) == 0, g, $urandom % 128);
        end
        idleCycles(3);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
Parametrised successor of the number-guessing game controller. It consumes a decoded guess value plus a one-cycle enter pulse from the keypad/display path and a free-running random word. It drives the 3-bit text-LCD command code, a trial counter, live lower/upper hint bounds and a win counter. New over the previous generation: configurable range, trial count and width; out-of-range rejection that does not consume a trial; optional per-guess timeout; and bound tracking.

Parameters:
W, 7, width of guess/target/bound values
MAX_VAL, 99, largest legal target/guess; constraint MAX_VAL < 2^W <= 2*(MAX_VAL+1)
MAX_TRIALS, 5, guesses per round (1..15)
TIMEOUT_CYC, 0, cycles without a guess in WAIT before a trial is forfeited; 0 disables
STRICT_RANGE, 1, 1: reject guesses outside current [lo,hi]; 0: reject only guess > MAX_VAL

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
rand_in  in  W  free-running random word, sampled in INIT only
guess_in  in  W  binary guess value, valid with guess_valid
guess_valid  in  1  one-cycle enter pulse
guess_ready  out  1  high in WAIT and END (guess accepted)
cmd_out  out  3  LCD command: 000 correct, 001 failed, 010 up, 011 down, 100 retry?, 101 start, 110 enter number, 111 out of range
cmd_strobe  out  1  one-cycle pulse on every cycle cmd_out is written
trials_left  out  4  remaining guesses this round
lo_bound  out  W  current lowest possible target
hi_bound  out  W  current highest possible target
win_cnt  out  8  rounds won, saturating at 255
game_state  out  3  INIT=000, WAIT=001, HINT=010, END=011

Behaviour:
- Reset (rst==0 at posedge): state INIT, cmd_out 110, cmd_strobe 0, trials_left 0, lo 0, hi MAX_VAL, win_cnt 0, target 0, timeout counter 0. Reset mid-round discards the round; win_cnt is cleared.
- All registered; a guess_valid sampled at edge N changes outputs after edge N. guess_valid is ignored (no effect, no strobe) in INIT and HINT.
- INIT (1 cycle): target = r if r <= MAX_VAL, else r-(MAX_VAL+1), where r = rand_in[W-1:0]. Set trials_left=MAX_TRIALS, lo=0, hi=MAX_VAL, cmd=110 with strobe. Go to WAIT.
- WAIT, guess_valid, guess g:
  - g illegal (g>MAX_VAL, or STRICT_RANGE and g<lo or g>hi): cmd=111 with strobe; trials unchanged; stay in WAIT.
  - g==target: cmd=000; win_cnt+1 (saturating); go to END.
  - Otherwise trials_left-1. If the result is 0: cmd=001, go to END.
  - Else if g>target: cmd=011, hi=g-1, go to HINT.
  - Else: cmd=010, lo=g+1, go to HINT.
- HINT (1 cycle): go to WAIT; cmd unchanged, no strobe.
- Timeout (TIMEOUT_CYC>0): counter clears on WAIT entry and on every accepted guess_valid, and increments each WAIT cycle otherwise. When it reaches TIMEOUT_CYC-1, apply a forfeited trial: trials-1, cmd=110 re-issued with strobe, or cmd=001 and go to END if trials reach 0. Bounds unchanged. guess_valid in the same cycle takes priority and the timeout is suppressed.
- END, guess_valid: g==1 → cmd=101 with strobe, go to INIT (101 is visible exactly 1 cycle, then INIT writes 110). Any other g → cmd=100 with strobe, stay in END. The timeout counter is inactive in END.
- Arithmetic: compares are unsigned W-bit. g-1 and g+1 never wrap, because they only occur when g>target>=0 or g<target<=MAX_VAL.

Decomposition:
- Package guess_game_pkg: state encodings, the eight cmd_out codes, and trial-counter width constant TW=4.
- One sub-module, guess_timeout_timer (clk, rst, clear, enable → expire pulse). It is generated only when TIMEOUT_CYC>0; otherwise expire is tied to 0.

Test Plan:
- Reset, rand_in=42 → after INIT: cmd 110, trials 5, lo 0, hi 99, state WAIT. Guess 42 → cmd 000, win_cnt 1, state END.
- rand_in=57 → guesses 80, 30, 57 → cmds 011 (hi 79), 010 (lo 31), 000. trials_left after the final guess stays at 3.
- rand_in=120 with W=7 → target 20. Five wrong guesses 10,11,12,13,14 → last cmd 001, trials 0, END. Guess 5 → cmd 100. Guess 1 → cmd 101 for 1 cycle, then 110, trials 5.
- STRICT_RANGE=1, target 50: guess 70 → hi 69. Guess 75 → cmd 111, trials stay 4, hi stays 69. Guess 120 → cmd 111.
- TIMEOUT_CYC=20: idle 20 cycles in WAIT → trials 4, cmd 110 strobe. guess_valid on the expiry cycle → guess processed, no forfeit.
- Deassert rst mid-HINT → next cycle state INIT, win_cnt 0, cmd 110. guess_valid asserted during INIT/HINT → no cmd_strobe.
